// File: rtl/tri_fetch.sv
// tri_fetch: per-frame indexed-mesh walker feeding triangles to the rasterizer
// over a valid/ready handshake, with index and vertex ROM fetch pipelines.
module tri_fetch #(
  parameter int NUM_VERTICES = 8,
  parameter int NUM_TRIS = 12,
  parameter int COORD_WIDTH = 9,
  parameter int READ_LATENCY = 2,
  localparam int IW = (NUM_VERTICES > 1) ? $clog2(NUM_VERTICES) : 1,
  localparam int TW = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     new_frame_in,
  output logic [TW-1:0]            idx_addr_out,
  input  logic [3*IW-1:0]          idx_data_in,
  output logic [IW-1:0]            vtx_addr_out,
  input  logic [3*COORD_WIDTH-1:0] vtx_data_in,
  output logic [COORD_WIDTH-1:0]   vert1_out [2:0],
  output logic [COORD_WIDTH-1:0]   vert2_out [2:0],
  output logic [COORD_WIDTH-1:0]   vert3_out [2:0],
  output logic                     tri_valid_out,
  input  logic                     tri_ready_in,
  output logic                     obj_done_out,
  output logic                     busy_out,
  output logic                     frame_overrun_out,
  output logic                     idx_err_out
);
  localparam int L = READ_LATENCY;
  localparam int CW = $clog2(2 * L + 5);
  localparam int C = COORD_WIDTH;
  localparam logic [IW:0] NV = (IW + 1)'(NUM_VERTICES);
  typedef enum logic [1:0] {IDLE, IDX_RD, VTX_RD, PRESENT} state_t;
  state_t r_state;
  logic [TW-1:0] r_t;
  logic [CW-1:0] r_cyc;
  logic [2*IW-1:0] r_idx;
  logic [C-1:0] r_v1 [2:0];
  logic [C-1:0] r_v2 [2:0];
  logic [C-1:0] w_vtx [2:0];
  logic [IW-1:0] w_i1, w_i2, w_i3;
  logic w_bad, w_adv, w_last;
  assign {w_i1, w_i2, w_i3} = idx_data_in;
  assign w_vtx[2] = vtx_data_in[3*C-1:2*C];
  assign w_vtx[1] = vtx_data_in[2*C-1:C];
  assign w_vtx[0] = vtx_data_in[C-1:0];
  assign w_bad = ({1'b0, w_i1} >= NV) || ({1'b0, w_i2} >= NV) || ({1'b0, w_i3} >= NV);
  assign w_last = r_t == TW'(NUM_TRIS - 1);
  // a skipped triangle advances one cycle after its error pulse, like a handshake would
  assign w_adv = (r_state == PRESENT && tri_ready_in) || (r_state == IDX_RD && r_cyc == CW'(L + 1));
  assign busy_out = r_state != IDLE;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_t <= '0;
      r_cyc <= '0;
      r_idx <= '0;
      r_v1 <= '{default: '0};
      r_v2 <= '{default: '0};
      vert1_out <= '{default: '0};
      vert2_out <= '{default: '0};
      vert3_out <= '{default: '0};
      idx_addr_out <= '0;
      vtx_addr_out <= '0;
      tri_valid_out <= 1'b0;
      obj_done_out <= 1'b0;
      frame_overrun_out <= 1'b0;
      idx_err_out <= 1'b0;
    end else begin
      obj_done_out <= 1'b0;
      idx_err_out <= 1'b0;
      frame_overrun_out <= new_frame_in && r_state != IDLE;
      r_cyc <= r_cyc + 1'b1;
      if (w_adv) begin
        tri_valid_out <= 1'b0;
        r_cyc <= '0;
        if (w_last) begin
          obj_done_out <= 1'b1;
          r_state <= IDLE;
          r_t <= '0;
        end else begin
          r_t <= r_t + 1'b1;
          idx_addr_out <= r_t + 1'b1;
          r_state <= IDX_RD;
        end
      end else begin
        case (r_state)
          IDLE: if (new_frame_in) begin
            r_state <= IDX_RD;
            r_t <= '0;
            idx_addr_out <= '0;
            r_cyc <= '0;
          end
          IDX_RD: if (r_cyc == CW'(L)) begin
            if (w_bad) idx_err_out <= 1'b1;
            else begin
              r_state <= VTX_RD;
              r_idx <= {w_i2, w_i3};
              vtx_addr_out <= w_i1;
            end
          end
          VTX_RD: begin
            if (r_cyc == CW'(L + 1)) vtx_addr_out <= r_idx[2*IW-1:IW];
            if (r_cyc == CW'(L + 2)) vtx_addr_out <= r_idx[IW-1:0];
            if (r_cyc == CW'(2 * L + 1)) r_v1 <= w_vtx;
            if (r_cyc == CW'(2 * L + 2)) r_v2 <= w_vtx;
            if (r_cyc == CW'(2 * L + 3)) begin
              vert1_out <= r_v1;
              vert2_out <= r_v2;
              vert3_out <= w_vtx;
              tri_valid_out <= 1'b1;
              r_state <= PRESENT;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tri_fetch.sv
// tb_tri_fetch: directed bench for tri_fetch with ROM models and a
// handshake scoreboard that predicts the presented triangle sequence.
module tb_tri_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic new_frame = 1'b0;
  logic ready = 1'b0;
  logic [3:0] ia;
  logic [8:0] ip, id;
  logic [2:0] va;
  logic [26:0] vp, vd;
  logic [8:0] v1 [2:0];
  logic [8:0] v2 [2:0];
  logic [8:0] v3 [2:0];
  logic valid, od, busy, ovr, err;
  logic [8:0] idx_rom [0:11];
  logic [26:0] vtx_rom [0:7];
  logic [81:0] snap;
  int n_vec = 0, n_bad = 0;
  int cyc = 0, hs_n = 0, hs_cyc = 0, od_n = 0, err_n = 0, mon_t = 0;
  int hs0, od0, err0;

  tri_fetch #(.NUM_VERTICES(6), .NUM_TRIS(12), .COORD_WIDTH(9), .READ_LATENCY(2)) dut (
    .clk_in(clk), .rst_in(rst), .new_frame_in(new_frame),
    .idx_addr_out(ia), .idx_data_in(id), .vtx_addr_out(va), .vtx_data_in(vd),
    .vert1_out(v1), .vert2_out(v2), .vert3_out(v3),
    .tri_valid_out(valid), .tri_ready_in(ready), .obj_done_out(od),
    .busy_out(busy), .frame_overrun_out(ovr), .idx_err_out(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ip <= idx_rom[ia];
    id <= ip;
    vp <= vtx_rom[va];
    vd <= vp;
  end

  assign snap = {valid, v1[2], v1[1], v1[0], v2[2], v2[1], v2[0], v3[2], v3[1], v3[0]};

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit bad_idx(input logic [8:0] e);
    return e[8:6] >= 6 || e[5:3] >= 6 || e[2:0] >= 6;
  endfunction

  always @(negedge clk) if (!rst) begin
    cyc++;
    if (!busy && new_frame) mon_t = 0;
    if (err) err_n++;
    if (od) begin
      od_n++;
      chk("od_lat", 96'(cyc - hs_cyc), 96'd1);
    end
    if (valid && ready) begin
      while (mon_t < 12 && bad_idx(idx_rom[mon_t])) mon_t++;
      if (mon_t < 12) begin
        chk("hs_v1", {v1[2], v1[1], v1[0]}, vtx_rom[idx_rom[mon_t][8:6]]);
        chk("hs_v2", {v2[2], v2[1], v2[0]}, vtx_rom[idx_rom[mon_t][5:3]]);
        chk("hs_v3", {v3[2], v3[1], v3[0]}, vtx_rom[idx_rom[mon_t][2:0]]);
      end
      hs_n++;
      hs_cyc = cyc;
      mon_t++;
    end
  end

  task automatic start_frame();
    hs0 = hs_n;
    od0 = od_n;
    err0 = err_n;
    @(posedge clk); #1 new_frame = 1'b1;
    @(posedge clk); #1 new_frame = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (od_n == od0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 96'(od_n != od0), 96'd1);
    @(negedge clk);
    chk("busy_fall", 96'(busy), 96'd0);
  endtask

  initial begin
    for (int k = 0; k < 12; k++) idx_rom[k] = {3'(k % 6), 3'((k + 1) % 6), 3'((k + 2) % 6)};
    vtx_rom[0] = {9'd20, 9'd20, 9'd30};
    vtx_rom[1] = {9'd20, 9'd40, 9'd30};
    vtx_rom[2] = {9'd40, 9'd20, 9'd30};
    vtx_rom[3] = {9'd100, 9'd200, 9'd300};
    vtx_rom[4] = {9'd7, 9'd511, 9'd0};
    vtx_rom[5] = {9'd256, 9'd1, 9'd255};
    vtx_rom[6] = '0;
    vtx_rom[7] = '0;
    #1 rst = 1'b1;
    #1 chk("rst_ctl", {ia, va, valid, od, busy, ovr, err}, 96'd0);
    chk("rst_vert", 96'(snap), 96'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // first triangle timing with ready high, then full frame
    ready = 1'b1;
    start_frame();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("c0_idx", 96'(ia), 96'd0);
      if (k >= 3 && k <= 5) chk("vtx_addr", 96'(va), 96'(k - 3));
      if (k == 7) chk("c7_valid", 96'(valid), 96'd0);
      if (k == 8) begin
        chk("c8_valid", 96'(valid), 96'd1);
        chk("c8_v1", {v1[2], v1[1], v1[0]}, {9'd20, 9'd20, 9'd30});
        chk("c8_v2", {v2[2], v2[1], v2[0]}, {9'd20, 9'd40, 9'd30});
        chk("c8_v3", {v3[2], v3[1], v3[0]}, {9'd40, 9'd20, 9'd30});
      end
    end
    wait_done();
    chk("f1_hs", 96'(hs_n - hs0), 96'd12);
    chk("f1_od", 96'(od_n - od0), 96'd1);

    // back-pressure: 20 stalled cycles on the first triangle
    ready = 1'b0;
    start_frame();
    for (int k = 0; k < 20 && !valid; k++) @(negedge clk);
    chk("bp_valid", 96'(valid), 96'd1);
    begin
      logic [81:0] held;
      held = snap;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        chk("bp_hold", 96'(snap), 96'(held));
      end
    end
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_idx", 96'(ia), 96'd1);
    chk("bp_drop", 96'(valid), 96'd0);
    chk("bp_hs1", 96'(hs_n - hs0), 96'd1);
    wait_done();
    chk("bp_hs", 96'(hs_n - hs0), 96'd12);

    // out-of-range index on triangle 3
    idx_rom[3] = {3'd1, 3'd7, 3'd2};
    start_frame();
    wait_done();
    chk("err_cnt", 96'(err_n - err0), 96'd1);
    chk("err_hs", 96'(hs_n - hs0), 96'd11);
    chk("err_od", 96'(od_n - od0), 96'd1);
    idx_rom[3] = {3'd3, 3'd4, 3'd5};

    // new_frame while busy
    start_frame();
    repeat (30) @(posedge clk);
    #1 new_frame = 1'b1;
    @(negedge clk);
    chk("ovr_pre", 96'(ovr), 96'd0);
    @(posedge clk); #1 new_frame = 1'b0;
    @(negedge clk);
    chk("ovr_pulse", 96'(ovr), 96'd1);
    @(negedge clk);
    chk("ovr_clear", 96'(ovr), 96'd0);
    wait_done();
    chk("ovr_hs", 96'(hs_n - hs0), 96'd12);

    // asynchronous reset in VTX_RD of triangle 2
    start_frame();
    for (int k = 0; k <= 22; k++) @(negedge clk);
    chk("pre_rst_busy", 96'(busy), 96'd1);
    rst = 1'b1;
    #1 chk("ar_ctl", {ia, va, valid, od, busy, ovr, err}, 96'd0);
    chk("ar_vert", 96'(snap), 96'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hs0 = hs_n;
    od0 = od_n;
    repeat (30) @(negedge clk);
    chk("ar_no_od", 96'(od_n - od0), 96'd0);
    chk("ar_no_hs", 96'(hs_n - hs0), 96'd0);

    start_frame();
    @(negedge clk);
    chk("rs_idx", 96'(ia), 96'd0);
    chk("rs_busy", 96'(busy), 96'd1);
    wait_done();
    chk("rs_hs", 96'(hs_n - hs0), 96'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tri_fetch.md
Name: tri_fetch

Overview:
- Upstream feeder for the rasterizer. It replaces the hard-wired constant triangle with a per-frame walk over an indexed mesh.
- On each new frame it reads every triangle's three vertex indices from an index ROM, then fetches the three vertices from a vertex ROM.
- It presents each triangle on the rasterizer's vert1/vert2/vert3 inputs with a valid/ready handshake.
- After the last triangle is accepted it pulses obj_done.

Parameters:
- NUM_VERTICES, 8, number of vertex ROM entries (max vertex index is NUM_VERTICES-1).
- NUM_TRIS, 12, number of index ROM entries; must be at least 1.
- COORD_WIDTH, 9, bits per coordinate.
- READ_LATENCY, 2, cycles from address to data for both ROMs; must be at least 1.
- Derived: IW = $clog2(NUM_VERTICES), with a minimum of 1; TW = $clog2(NUM_TRIS), with a minimum of 1.

Ports:
- clk_in  input  1  pixel clock; the only clock.
- rst_in  input  1  asynchronous, active-high reset.
- new_frame_in  input  1  one-cycle frame-start pulse from video_sig_gen.
- idx_addr_out  output  TW  index ROM address.
- idx_data_in  input  3*IW  {i1,i2,i3}, with i1 in the MSBs.
- vtx_addr_out  output  IW  vertex ROM address.
- vtx_data_in  input  3*COORD_WIDTH  {x,y,z}, with x in the MSBs.
- vert1_out, vert2_out, vert3_out  output  [COORD_WIDTH-1:0] [2:0]  [2]=x, [1]=y, [0]=z; connect directly to the rasterizer vert ports.
- tri_valid_out  output  1  triangle on vert*_out is valid.
- tri_ready_in  input  1  rasterizer accepts the triangle.
- obj_done_out  output  1  one-cycle pulse when all triangles of the frame have been accepted.
- busy_out  output  1  high in every state except IDLE.
- frame_overrun_out  output  1  one-cycle pulse when new_frame_in arrives while busy.
- idx_err_out  output  1  one-cycle pulse when an index is out of range.

Behaviour:
- Reset:
  - Asynchronous assertion forces state IDLE, the triangle counter to 0, and every output to 0, including vert*_out and the addresses.
  - Assertion mid-frame aborts the walk: no obj_done_out, no tri_valid_out.
- States: IDLE, IDX_RD, VTX_RD, PRESENT.
- IDLE:
  - new_frame_in high goes to IDX_RD with t=0.
  - Cycle 0 is the first cycle after the edge that sampled new_frame_in.
- IDX_RD:
  - idx_addr_out=t is driven in cycle 0.
  - Data is valid in cycle READ_LATENCY and is captured at the end of that cycle.
  - If any index is greater than or equal to NUM_VERTICES: pulse idx_err_out in the next cycle and skip the triangle (see triangle advance below).
  - Otherwise go to VTX_RD.
- VTX_RD:
  - vtx_addr_out = i1, i2, i3 in three consecutive cycles, L+1, L+2, L+3, where L = READ_LATENCY.
  - Each returned word is captured READ_LATENCY cycles after its address and steered to vert1, vert2 or vert3 respectively.
  - The address stream is pipelined: the bench must not see bubbles between the three addresses.
- PRESENT:
  - tri_valid_out rises in cycle 2L+4, which is 8 with the defaults.
  - vert*_out and tri_valid_out are held stable while tri_valid_out is high and tri_ready_in is low.
  - vert*_out update only when a new triangle is loaded; they are never cleared between triangles.
- Triangle advance (on handshake in cycle c, or after an idx error):
  - If t < NUM_TRIS-1: t increments and IDX_RD restarts, with idx_addr_out driven in cycle c+1.
  - Otherwise: pulse obj_done_out in cycle c+1 and return to IDLE.
  - tri_valid_out drops in cycle c+1 unless a new triangle is ready. It cannot be ready, so there is at least a 2L+4 cycle gap between triangles.
- Skipped final triangle: if the last triangle is skipped for a bad index, obj_done_out is still pulsed, in the cycle after idx_err_out.
- tri_ready_in while tri_valid_out is low: ignored.
- new_frame_in while busy: ignored; the current walk continues, and frame_overrun_out pulses in the next cycle.
- new_frame_in in the same cycle as the final handshake: counts as busy, so it is ignored and flagged.
- Counter width: t wraps only through reset or return to IDLE; it never exceeds NUM_TRIS-1.
- Arithmetic: none on coordinates; fields pass through unchanged.

Test Plan:
- Defaults, index ROM entry 0 = {0,1,2}, vertices 0..2 = (20,20,30), (20,40,30), (40,20,30), ready tied high:
  - tri_valid_out rises in cycle 8 after new_frame_in.
  - vert1_out=(20,20,30), vert2_out=(20,40,30), vert3_out=(40,20,30).
  - vtx_addr_out = 0, 1, 2 in cycles 3, 4, 5.
- Back-pressure: hold tri_ready_in low for 20 cycles.
  - Outputs are stable for all 20 cycles.
  - Accept in cycle c, then idx_addr_out=1 in cycle c+1.
  - Exactly one handshake per triangle.
- NUM_TRIS=12, ready high:
  - Exactly 12 handshakes.
  - obj_done_out is a single pulse one cycle after the 12th handshake.
  - busy_out then falls.
- NUM_VERTICES=6, triangle 3 = {1,7,2}:
  - idx_err_out pulses once.
  - 11 handshakes total; obj_done_out still pulses.
  - Triangle 3 is never presented.
- new_frame_in pulse mid-walk:
  - frame_overrun_out pulses one cycle later.
  - The walk completes normally with 12 triangles.
- rst_in asserted while in VTX_RD, with no clock edge:
  - All outputs are 0 immediately.
  - No obj_done_out.
  - The next new_frame_in restarts at idx_addr_out=0.
